// File: rtl/display_pkg.sv
// Shared types and glyph constants for the seven-segment display driver.
// Segment vectors are logical (1 = lit) with bit order {g,f,e,d,c,b,a}.
// Optional feature macro: DISPLAY_HEX_DIGITS_EN (hex glyphs for 10..15).
package display_pkg;

    typedef logic [6:0] seg_t;

    //                          gfedcba
    localparam seg_t SEG_0    = 7'b0111111;
    localparam seg_t SEG_1    = 7'b0000110;
    localparam seg_t SEG_2    = 7'b1011011;
    localparam seg_t SEG_3    = 7'b1001111;
    localparam seg_t SEG_4    = 7'b1100110;
    localparam seg_t SEG_5    = 7'b1101101;
    localparam seg_t SEG_6    = 7'b1111101;
    localparam seg_t SEG_7    = 7'b0000111;
    localparam seg_t SEG_8    = 7'b1111111;
    localparam seg_t SEG_9    = 7'b1101111;
    localparam seg_t SEG_A    = 7'b1110111;
    localparam seg_t SEG_B    = 7'b1111100;
    localparam seg_t SEG_C    = 7'b0111001;
    localparam seg_t SEG_D    = 7'b1011110;
    localparam seg_t SEG_E    = 7'b1111001;
    localparam seg_t SEG_F    = 7'b1110001;
    localparam seg_t SEG_DASH = 7'b1000000;
    localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/display_decoder.sv
// Combinational digit-to-segment decoder producing the logical pattern.
// Ports:
//   data  in  4  digit value 0..15
//   seg   out 7  logical segments {g,f,e,d,c,b,a}, 1 = lit
// Macro DISPLAY_HEX_DIGITS_EN: when defined, 10..15 show hex glyphs A b C d E F;
// otherwise they show a dash (g only).
module display_decoder
    import display_pkg::*;
(
    input  logic [3:0] data,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (data)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef DISPLAY_HEX_DIGITS_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg = SEG_DASH;
`endif
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_7seg.sv
// Single-digit seven-segment display driver with registered pad outputs.
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   data       in   4  digit value 0..15
//   a..g       out  1  segment lines (a top, b top right, ... g middle)
//   dp         out  1  decimal point, held at the inactive level
// Parameter ACTIVE_LOW: 1 drives a lit segment as 0 (common anode), 0 drives it as 1.
// Macro DISPLAY_HEX_DIGITS_EN selects hex glyphs for 10..15 (see display_decoder).
module display_7seg
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp
);

    seg_t       seg_logic;
    seg_t       seg_phys;
    logic [7:0] out_q;   // {dp,g,f,e,d,c,b,a} at pad level

    display_decoder u_decoder (
        .data (data),
        .seg  (seg_logic)
    );

    // Polarity is applied after decode so the glyph table stays in lit-is-1 form.
    assign seg_phys = seg_logic ^ {7{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= {8{ACTIVE_LOW}};
        end else begin
            out_q <= {ACTIVE_LOW, seg_phys};
        end
    end

    assign a  = out_q[0];
    assign b  = out_q[1];
    assign c  = out_q[2];
    assign d  = out_q[3];
    assign e  = out_q[4];
    assign f  = out_q[5];
    assign g  = out_q[6];
    assign dp = out_q[7];

endmodule

// File: tb/tb_display_7seg.sv
// Self-checking bench for display_7seg: both polarities instantiated side by side,
// table-driven directed vectors, hand-written latency sequence, and randomized
// stimulus against a reference model built from lists of lit segment letters.
module tb_display_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data;
    logic [7:0] phys_al;   // {dp,g,f,e,d,c,b,a}, ACTIVE_LOW=1 instance
    logic [7:0] phys_ah;   // same, ACTIVE_LOW=0 instance

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_7seg #(.ACTIVE_LOW(1'b1)) u_dut_al (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .a    (phys_al[0]),
        .b    (phys_al[1]),
        .c    (phys_al[2]),
        .d    (phys_al[3]),
        .e    (phys_al[4]),
        .f    (phys_al[5]),
        .g    (phys_al[6]),
        .dp   (phys_al[7])
    );

    display_7seg #(.ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .a    (phys_ah[0]),
        .b    (phys_ah[1]),
        .c    (phys_ah[2]),
        .d    (phys_ah[3]),
        .e    (phys_ah[4]),
        .f    (phys_ah[5]),
        .g    (phys_ah[6]),
        .dp   (phys_ah[7])
    );

    // Reference: which segment letters are lit for each value.
    function automatic string lit_letters(input logic [3:0] v);
        case (v)
            4'd0: return "abcdef";
            4'd1: return "bc";
            4'd2: return "abdeg";
            4'd3: return "abcdg";
            4'd4: return "bcfg";
            4'd5: return "acdfg";
            4'd6: return "acdefg";
            4'd7: return "abc";
            4'd8: return "abcdefg";
            4'd9: return "abcdfg";
            default: begin
`ifdef DISPLAY_HEX_DIGITS_EN
                case (v)
                    4'd10:   return "abcefg";
                    4'd11:   return "cdefg";
                    4'd12:   return "adef";
                    4'd13:   return "bcdeg";
                    4'd14:   return "adefg";
                    default: return "aefg";
                endcase
`else
                return "g";
`endif
            end
        endcase
    endfunction

    function automatic logic [6:0] lit_bits(input logic [3:0] v);
        string      s;
        logic [6:0] r;
        int         idx;
        s = lit_letters(v);
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - int'("a");
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    // Pad levels one edge after sampling (r, v) for the given polarity.
    function automatic logic [7:0] model(input logic r, input logic [3:0] v, input logic al);
        logic [6:0] lit;
        lit = r ? 7'b0 : lit_bits(v);
        return {1'b0, lit} ^ {8{al}};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
        end
    endtask

    // Apply inputs and advance to just after the next rising edge.
    task automatic step(input logic r, input logic [3:0] v);
        rst  = r;
        data = v;
        @(posedge clk);
        #1;
    endtask

    // Compare both instances against a logical pattern (1 = lit) from the glyph table.
    task automatic check_logical(input string name, input logic [6:0] lit);
        check({name, "_al"}, phys_al, {1'b1, ~lit});
        check({name, "_ah"}, phys_ah, {1'b0, lit});
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] data;
        logic [6:0] lit;     // expected logical gfedcba after the edge
        string      name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst  = 1'b1;
        data = 4'd8;

        vecs.push_back('{1'b1, 4'd8, 7'b0000000, "reset0"});
        vecs.push_back('{1'b1, 4'd8, 7'b0000000, "reset1"});
        vecs.push_back('{1'b0, 4'd0, 7'b0111111, "dig0"});
        vecs.push_back('{1'b0, 4'd1, 7'b0000110, "dig1"});
        vecs.push_back('{1'b0, 4'd2, 7'b1011011, "dig2"});
        vecs.push_back('{1'b0, 4'd3, 7'b1001111, "dig3"});
        vecs.push_back('{1'b0, 4'd4, 7'b1100110, "dig4"});
        vecs.push_back('{1'b0, 4'd5, 7'b1101101, "dig5"});
        vecs.push_back('{1'b0, 4'd6, 7'b1111101, "dig6"});
        vecs.push_back('{1'b0, 4'd7, 7'b0000111, "dig7"});
        vecs.push_back('{1'b0, 4'd8, 7'b1111111, "dig8"});
        vecs.push_back('{1'b0, 4'd9, 7'b1101111, "dig9"});
        vecs.push_back('{1'b0, 4'd6, 7'b1111101, "pre_rst6"});
        vecs.push_back('{1'b1, 4'd6, 7'b0000000, "midrst6"});
        vecs.push_back('{1'b0, 4'd6, 7'b1111101, "post_rst6"});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].data);
            check_logical(vecs[i].name, vecs[i].lit);
        end

        // Upper range glyph for 12.
        step(1'b0, 4'd12);
`ifdef DISPLAY_HEX_DIGITS_EN
        check_logical("upper12", 7'b0111001);
`else
        check_logical("upper12", 7'b1000000);
`endif

        // Latency: 3 then 7; output must not change before the edge that samples 7.
        step(1'b0, 4'd3);
        check_logical("lat3", 7'b1001111);
        data = 4'd7;
        #3;
        check_logical("lat3_hold", 7'b1001111);
        @(posedge clk);
        #1;
        check_logical("lat7", 7'b0000111);

        // dp at inactive level for every value and polarity.
        for (int v = 0; v < 16; v++) begin
            step(1'b0, 4'(v));
            check("dp_al", {7'b0, phys_al[7]}, 8'd1);
            check("dp_ah", {7'b0, phys_ah[7]}, 8'd0);
        end

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [3:0] v;
            r = ($urandom_range(0, 9) == 0);
            v = 4'($urandom_range(0, 15));
            step(r, v);
            check("rand_al", phys_al, model(r, v, 1'b1));
            check("rand_ah", phys_ah, model(r, v, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
